// File: rtl/psum_collector.sv
// psum_collector: de-skews the bottom-row partial sums of a systolic array and
// buffers each aligned row in a DEPTH-entry first-word fall-through FIFO.
// Latency: OUT_VALID rises the cycle after the push edge, COLS-1 EN-edges after column 0.
// Backpressure: STALL = FIFO full; a row pushed while full with no pop is dropped and OVERFLOW latches.
//
// Ports:
//   CLK, ASYNC_RST (async, active-low), SYNC_RST (sync, active-high)
//   EN        - array advance strobe; delay lines and tag pipeline shift only when high
//   PSUM_IN   - COLS x 2*WIDTH skewed psums, column j at [j*2*WIDTH +: 2*WIDTH]
//   IN_VALID  - marks column 0 of a result row at the current EN edge
//   OUT_DATA / OUT_VALID / OUT_READY - aligned row, FIFO head, valid/ready handshake
//   STALL     - FIFO full
//   OVERFLOW  - sticky, a row was discarded
//   DROP_CNT  - saturating discarded-row count, present only with PSUM_COLLECTOR_DROP_CNT_EN

module psum_collector #(
    parameter int WIDTH = 8,
    parameter int COLS  = 4,
    parameter int DEPTH = 4
) (
    input  logic                    CLK,
    input  logic                    ASYNC_RST,
    input  logic                    SYNC_RST,
    input  logic                    EN,
    input  logic [COLS*2*WIDTH-1:0] PSUM_IN,
    input  logic                    IN_VALID,
    output logic [COLS*2*WIDTH-1:0] OUT_DATA,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic                    STALL,
`ifdef PSUM_COLLECTOR_DROP_CNT_EN
    output logic [7:0]              DROP_CNT,
`endif
    output logic                    OVERFLOW
);

    localparam int PW   = 2 * WIDTH;
    localparam int RW   = COLS * PW;
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [RW-1:0] row;      // de-skewed row presented to the FIFO tail
    logic          tag_out;  // IN_VALID delayed by COLS-1 EN-edges

    // Column j arrives j EN-edges late, so it is delayed COLS-1-j stages to
    // line up with the last column, which is taken straight from PSUM_IN.
    for (genvar j = 0; j < COLS; j++) begin : g_col
        localparam int S = COLS - 1 - j;
        if (S == 0) begin : g_direct
            assign row[j*PW +: PW] = PSUM_IN[j*PW +: PW];
        end else begin : g_dly
            logic [PW-1:0] line_q [S];
            logic [PW-1:0] line_d [S];

            always_comb begin
                line_d = line_q;
                if (SYNC_RST) begin
                    for (int k = 0; k < S; k++) line_d[k] = '0;
                end else if (EN) begin
                    line_d[0] = PSUM_IN[j*PW +: PW];
                    for (int k = 1; k < S; k++) line_d[k] = line_q[k-1];
                end
            end

            always_ff @(posedge CLK or negedge ASYNC_RST) begin
                if (!ASYNC_RST) begin
                    for (int k = 0; k < S; k++) line_q[k] <= '0;
                end else begin
                    line_q <= line_d;
                end
            end

            assign row[j*PW +: PW] = line_q[S-1];
        end
    end

    if (COLS == 1) begin : g_tag_direct
        assign tag_out = IN_VALID;
    end else begin : g_tag
        logic [COLS-2:0] tag_q;
        logic [COLS-2:0] tag_d;

        always_comb begin
            tag_d = tag_q;
            if (SYNC_RST) begin
                tag_d = '0;
            end else if (EN) begin
                tag_d[0] = IN_VALID;
                for (int k = 1; k < COLS - 1; k++) tag_d[k] = tag_q[k-1];
            end
        end

        always_ff @(posedge CLK or negedge ASYNC_RST) begin
            if (!ASYNC_RST) tag_q <= '0;
            else            tag_q <= tag_d;
        end

        assign tag_out = tag_q[COLS-2];
    end

    // Output FIFO
    logic [RW-1:0]   mem_q [DEPTH];
    logic [RW-1:0]   mem_d [DEPTH];
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            full, push, pop, wr_ok, drop;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
    endfunction

    assign full  = (cnt_q == CNTW'(DEPTH));
    assign push  = EN & tag_out;
    assign pop   = OUT_VALID & OUT_READY;
    // When full, a same-edge pop frees the head slot, which is exactly the slot
    // the write pointer addresses, so the push still lands.
    assign wr_ok = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (SYNC_RST) begin
            for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            if (wr_ok) begin
                mem_d[wr_ptr_q] = row;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            if (wr_ok && !pop)      cnt_d = cnt_q + CNTW'(1);
            else if (!wr_ok && pop) cnt_d = cnt_q - CNTW'(1);
            if (drop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    assign OUT_DATA  = mem_q[rd_ptr_q];
    assign OUT_VALID = (cnt_q != '0);
    assign STALL     = full;
    assign OVERFLOW  = ovf_q;

`ifdef PSUM_COLLECTOR_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (SYNC_RST)                         drop_cnt_d = '0;
        else if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) drop_cnt_q <= '0;
        else            drop_cnt_q <= drop_cnt_d;
    end

    assign DROP_CNT = drop_cnt_q;
`endif

endmodule

// File: tb/tb_psum_collector.sv
// Bench for psum_collector (WIDTH=8, COLS=4, DEPTH=4): vector table, directed
// corner sequences and random traffic, all checked against a queue-based model
// that rebuilds each row from the EN-edge history of PSUM_IN/IN_VALID.

module tb_psum_collector;

    localparam int WIDTH = 8;
    localparam int COLS  = 4;
    localparam int DEPTH = 4;
    localparam int PW    = 2 * WIDTH;
    localparam int RW    = COLS * PW;

    logic          CLK = 1'b0;
    logic          ASYNC_RST, SYNC_RST, EN, IN_VALID, OUT_READY;
    logic [RW-1:0] PSUM_IN, OUT_DATA;
    logic          OUT_VALID, STALL, OVERFLOW;
`ifdef PSUM_COLLECTOR_DROP_CNT_EN
    logic [7:0]    DROP_CNT;
`endif

    always #5 CLK = ~CLK;

    psum_collector #(.WIDTH(WIDTH), .COLS(COLS), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .ASYNC_RST (ASYNC_RST),
        .SYNC_RST  (SYNC_RST),
        .EN        (EN),
        .PSUM_IN   (PSUM_IN),
        .IN_VALID  (IN_VALID),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .STALL     (STALL),
`ifdef PSUM_COLLECTOR_DROP_CNT_EN
        .DROP_CNT  (DROP_CNT),
`endif
        .OVERFLOW  (OVERFLOW)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit            hv[$];   // IN_VALID seen at each EN edge since reset
    logic [RW-1:0] hd[$];   // PSUM_IN seen at each EN edge since reset
    logic [RW-1:0] mq[$];   // rows buffered in the FIFO
    bit            m_ovf;
    int            m_drop;

    function automatic void m_clear();
        hv.delete();
        hd.delete();
        mq.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
    endfunction

    // A row whose column 0 arrived at EN-edge k is complete at EN-edge k+COLS-1;
    // its column j is whatever PSUM_IN carried at EN-edge k+j.
    function automatic void m_edge(input bit en, input bit iv, input logic [RW-1:0] psum,
                                   input bit rdy, input bit srst);
        bit            pop, push;
        int            k;
        logic [RW-1:0] r;
        if (srst) begin
            m_clear();
            return;
        end
        pop  = (mq.size() > 0) && rdy;
        push = 1'b0;
        r    = '0;
        if (en) begin
            hv.push_back(iv);
            hd.push_back(psum);
            k = hv.size() - COLS;
            if (k >= 0 && hv[k]) begin
                push = 1'b1;
                for (int j = 0; j < COLS; j++) r[j*PW +: PW] = hd[k+j][j*PW +: PW];
            end
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(r);
            else begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
    endfunction

    task automatic m_check();
        chk("out_valid", OUT_VALID, mq.size() > 0);
        chk("stall", STALL, mq.size() == DEPTH);
        chk("overflow", OVERFLOW, m_ovf);
        if (mq.size() > 0) chk("out_data", OUT_DATA, mq[0]);
`ifdef PSUM_COLLECTOR_DROP_CNT_EN
        chk("drop_cnt", DROP_CNT, m_drop);
`endif
    endtask

    // One clock: drive inputs, advance model, sample 1 time unit after the edge.
    task automatic cyc(input bit en, input bit iv, input logic [RW-1:0] psum,
                       input bit rdy, input bit srst);
        EN = en; IN_VALID = iv; PSUM_IN = psum; OUT_READY = rdy; SYNC_RST = srst;
        m_edge(en, iv, psum, rdy, srst);
        @(posedge CLK);
        #1;
        m_check();
    endtask

    // Continuous skewed stream: at EN-edge e, column j carries row (e-j) value.
    int se = 16;

    function automatic logic [RW-1:0] rowval(input int r);
        logic [RW-1:0] v;
        for (int j = 0; j < COLS; j++) v[j*PW +: PW] = 16'(r * 256 + j);
        return v;
    endfunction

    function automatic logic [RW-1:0] sval(input int e);
        logic [RW-1:0] v;
        for (int j = 0; j < COLS; j++) v[j*PW +: PW] = 16'((e - j) * 256 + j);
        return v;
    endfunction

    task automatic scyc(input bit en, input bit iv, input bit rdy);
        if (en) begin
            cyc(1'b1, iv, sval(se), rdy, 1'b0);
            se++;
        end else begin
            cyc(1'b0, iv, {$urandom, $urandom}, rdy, 1'b0);
        end
    endtask

    typedef struct {
        bit            en;
        bit            iv;
        logic [RW-1:0] psum;
        bit            rdy;
        bit            xv;
        logic [RW-1:0] xd;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int r0;

        tbl[0]  = '{1'b1, 1'b0, 64'h0,                    1'b1, 1'b0, 64'h0};
        tbl[1]  = '{1'b1, 1'b1, 64'h0000_0000_0000_0100,  1'b1, 1'b0, 64'h0};
        tbl[2]  = '{1'b1, 1'b0, 64'h0000_0000_0101_0000,  1'b1, 1'b0, 64'h0};
        tbl[3]  = '{1'b1, 1'b0, 64'h0000_0102_0000_0000,  1'b1, 1'b0, 64'h0};
        tbl[4]  = '{1'b1, 1'b0, 64'h0103_0000_0000_0000,  1'b1, 1'b1, 64'h0103_0102_0101_0100};
        tbl[5]  = '{1'b1, 1'b0, 64'h0,                    1'b1, 1'b0, 64'h0};
        tbl[6]  = '{1'b1, 1'b1, 64'h0000_0000_0000_0200,  1'b1, 1'b0, 64'h0};
        tbl[7]  = '{1'b0, 1'b0, 64'hdead_beef_dead_beef,  1'b1, 1'b0, 64'h0};
        tbl[8]  = '{1'b1, 1'b0, 64'h0000_0000_0201_0000,  1'b1, 1'b0, 64'h0};
        tbl[9]  = '{1'b0, 1'b1, 64'hffff_ffff_ffff_ffff,  1'b1, 1'b0, 64'h0};
        tbl[10] = '{1'b1, 1'b0, 64'h0000_0202_0000_0000,  1'b1, 1'b0, 64'h0};
        tbl[11] = '{1'b0, 1'b0, 64'h1234_5678_9abc_def0,  1'b1, 1'b0, 64'h0};
        tbl[12] = '{1'b1, 1'b0, 64'h0203_0000_0000_0000,  1'b1, 1'b1, 64'h0203_0202_0201_0200};
        tbl[13] = '{1'b0, 1'b0, 64'h0,                    1'b1, 1'b0, 64'h0};

        m_clear();
        ASYNC_RST = 1'b0; SYNC_RST = 1'b0; EN = 1'b0; IN_VALID = 1'b0;
        OUT_READY = 1'b0; PSUM_IN = '0;
        #12;
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_stall", STALL, 0);
        chk("rst_overflow", OVERFLOW, 0);
        chk("rst_out_data", OUT_DATA, 0);
        ASYNC_RST = 1'b1;
        @(posedge CLK);
        #1;

        // Single row, then the same row shape with EN gaps
        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].en, tbl[i].iv, tbl[i].psum, tbl[i].rdy, 1'b0);
            chk($sformatf("tbl%0d_valid", i), OUT_VALID, tbl[i].xv);
            if (tbl[i].xv) chk($sformatf("tbl%0d_data", i), OUT_DATA, tbl[i].xd);
        end

        // Fill to full, overflow on the fifth row, then drain in order
        r0 = se;
        for (int i = 0; i < 5; i++) scyc(1'b1, 1'b1, 1'b0);
        scyc(1'b1, 1'b0, 1'b0);
        chk("fill3_stall", STALL, 0);
        scyc(1'b1, 1'b0, 1'b0);
        chk("fill4_stall", STALL, 1);
        chk("fill4_ovf", OVERFLOW, 0);
        scyc(1'b1, 1'b0, 1'b0);
        chk("drop_ovf", OVERFLOW, 1);
`ifdef PSUM_COLLECTOR_DROP_CNT_EN
        chk("drop_cnt1", DROP_CNT, 1);
`endif
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d", k), OUT_DATA, rowval(r0 + k));
            scyc(1'b0, 1'b0, 1'b1);
        end
        chk("drained_valid", OUT_VALID, 0);
        chk("ovf_sticky", OVERFLOW, 1);

        // Sync reset with two rows buffered and one in flight
        for (int i = 0; i < 2; i++) scyc(1'b1, 1'b1, 1'b0);
        scyc(1'b1, 1'b0, 1'b0);
        scyc(1'b1, 1'b0, 1'b0);
        scyc(1'b1, 1'b1, 1'b0);
        chk("pre_srst_valid", OUT_VALID, 1);
        cyc(1'b1, 1'b0, sval(se), 1'b1, 1'b1);
        se++;
        chk("srst_valid", OUT_VALID, 0);
        chk("srst_stall", STALL, 0);
        chk("srst_ovf", OVERFLOW, 0);
        for (int i = 0; i < 6; i++) begin
            scyc(1'b1, 1'b0, 1'b1);
            chk("inflight_gone", OUT_VALID, 0);
        end

        // Full FIFO with push and pop on the same edge
        r0 = se;
        for (int i = 0; i < 5; i++) scyc(1'b1, 1'b1, 1'b0);
        scyc(1'b1, 1'b0, 1'b0);
        scyc(1'b1, 1'b0, 1'b0);
        chk("full_before", STALL, 1);
        scyc(1'b1, 1'b0, 1'b1);
        chk("pp_stall", STALL, 1);
        chk("pp_ovf", OVERFLOW, 0);
        chk("pp_head", OUT_DATA, rowval(r0 + 1));
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("pp_drain%0d", k), OUT_DATA, rowval(r0 + k));
            scyc(1'b0, 1'b0, 1'b1);
        end
        chk("pp_empty", OUT_VALID, 0);

        // Asynchronous reset between edges with rows buffered
        for (int i = 0; i < 3; i++) scyc(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) scyc(1'b1, 1'b0, 1'b0);
        chk("pre_arst_valid", OUT_VALID, 1);
        #3;
        ASYNC_RST = 1'b0;
        #1;
        m_clear();
        chk("arst_valid", OUT_VALID, 0);
        chk("arst_stall", STALL, 0);
        chk("arst_ovf", OVERFLOW, 0);
        chk("arst_data", OUT_DATA, 0);
`ifdef PSUM_COLLECTOR_DROP_CNT_EN
        chk("arst_drop", DROP_CNT, 0);
`endif
        @(posedge CLK);
        #1;
        chk("arst_hold_valid", OUT_VALID, 0);
        ASYNC_RST = 1'b1;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                {$urandom, $urandom}, $urandom_range(0, 2) == 0,
                $urandom_range(0, 99) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
